// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
//   Shared definitions for the layer-to-DRAM responder (dram_resp) and its
//   read pipeline (dram_rd_pipe).
//   Contents:
//     DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default word and word-address widths
//     word_t / addr_t                 : word and address types at the defaults
//     MAX_RD_LAT                      : deepest supported read latency
//     CNT_WIDTH_DEF / CNT_SAT         : default counter width and the value at
//                                       which the request counters stick
// -----------------------------------------------------------------------------
package dram_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 18;
    localparam int MAX_RD_LAT     = 8;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

    // Request counters saturate at all-ones instead of wrapping.
    localparam logic [CNT_WIDTH_DEF-1:0] CNT_SAT = '1;

endpackage : dram_pkg

// File: rtl/dram_rd_pipe.sv
// -----------------------------------------------------------------------------
// dram_rd_pipe
//   DEPTH-stage shift register of {valid, data} carrying read words from the
//   memory read register to the dram_resp outputs.
//   Stage 1 data is the memory's own registered read output (data_in); stage 1
//   valid is registered here from vld_in. Stages 2..DEPTH are local registers.
//   Ports:
//     clk, srstn    : clock; asynchronous active-low reset (valid bits only)
//     vld_in        : read accepted on this edge
//     data_in       : registered memory read word (stage 1 data)
//     vld_out       : valid of the last stage (one strobe per returned word)
//     data_out      : last returned word, 0 until the first return after reset
// -----------------------------------------------------------------------------
module dram_rd_pipe
    import dram_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    if (DEPTH < 1 || DEPTH > MAX_RD_LAT) begin : g_bad_depth
        $error("dram_rd_pipe: DEPTH out of range");
    end

    logic [DEPTH-1:0]       vld_q, vld_d;
    logic                   seen_q, seen_d;
    logic [DEPTH*WIDTH-1:0] chain;

    assign chain[WIDTH-1:0] = data_in;

    // Data of a stage only moves when the stage behind it holds a valid word,
    // so the last stage keeps the most recent returned word while idle.
    genvar gi;
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] data_q, data_d;

        always_comb begin
            data_d = data_q;
            if (vld_q[gi-1]) begin
                data_d = chain[(gi-1)*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            data_q <= data_d;
        end

        assign chain[gi*WIDTH +: WIDTH] = data_q;
    end

    always_comb begin
        vld_d  = (vld_q << 1) | DEPTH'(vld_in);
        seen_d = seen_q | vld_q[DEPTH-1];
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            vld_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            seen_q <= seen_d;
        end
    end

    // Data registers are not reset; masking until the first return makes the
    // output read as 0 out of reset without resetting the datapath.
    assign vld_out  = vld_q[DEPTH-1];
    assign data_out = (seen_q | vld_q[DEPTH-1]) ? chain[(DEPTH-1)*WIDTH +: WIDTH] : '0;

endmodule : dram_rd_pipe

// File: rtl/dram_resp.sv
// -----------------------------------------------------------------------------
// dram_resp
//   Behavioural/on-chip DRAM responder behind the layer engines. Accepts one
//   read and one write per cycle (no backpressure) and returns read words
//   RD_LAT cycles after the request edge with a one-cycle dram_valid strobe.
//   Same-address read and write in one cycle return the old word.
//   Ports:
//     clk, srstn                      : clock; asynchronous active-low reset
//     dram_en_rd, addr_rd             : read request and word address
//     dram_en_wr, addr_wr, data_wr    : write request, address and data
//     data_rd, dram_valid             : returned word and its strobe
//     rd_cnt, wr_cnt                  : saturating accepted-request counters
//     addr_err                        : sticky out-of-range flag (optional)
//   Build option: define DRAM_RESP_ADDR_CHK_EN to add addr_err, discard
//   out-of-range writes and return 0 for out-of-range reads. Without it,
//   addresses wrap modulo MEM_DEPTH.
// -----------------------------------------------------------------------------
module dram_resp
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_DEPTH  = 262144,
    parameter int RD_LAT     = 2,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  dram_en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    input  logic                  dram_en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  dram_valid,
`ifdef DRAM_RESP_ADDR_CHK_EN
    output logic                  addr_err,
`endif
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic                  rd_oob, wr_oob;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    // Upper address bits are dropped: the memory wraps modulo its depth.
    assign rd_idx = addr_rd[IDX_W-1:0];
    assign wr_idx = addr_wr[IDX_W-1:0];

`ifdef DRAM_RESP_ADDR_CHK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
    logic addr_err_q, addr_err_d;

    assign rd_oob = ({1'b0, addr_rd} >= DEPTH_LIM);
    assign wr_oob = ({1'b0, addr_wr} >= DEPTH_LIM);

    always_comb begin
        addr_err_d = addr_err_q | (dram_en_rd & rd_oob) | (dram_en_wr & wr_oob);
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    // Memory array with registered read; neither is reset. The read samples
    // the pre-write contents, giving read-before-write on a same-address hit.
    // rd_word_q only loads on a read so it can serve as held stage-1 data.
    always_ff @(posedge clk) begin
        if (dram_en_wr && !wr_oob) begin
            mem[wr_idx] <= data_wr;
        end
        if (dram_en_rd) begin
            rd_word_q <= rd_oob ? '0 : mem[rd_idx];
        end
    end

    dram_rd_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (DATA_WIDTH)
    ) u_rd_pipe (
        .clk      (clk),
        .srstn    (srstn),
        .vld_in   (dram_en_rd),
        .data_in  (rd_word_q),
        .vld_out  (dram_valid),
        .data_out (data_rd)
    );

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (dram_en_rd && rd_cnt_q != CNT_MAX) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (dram_en_wr && wr_cnt_q != CNT_MAX) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;

endmodule : dram_resp

// File: tb/tb_dram_resp.sv
// -----------------------------------------------------------------------------
// tb_dram_resp
//   Three responders (RD_LAT = 2, 1, 8) share one request stream. Each clock
//   step applies the request at the rising edge, then the outputs are compared
//   on the falling edge against expected words held in per-latency delay lines
//   fed from a reference memory. Directed checks with hand-computed values
//   cover reset, a single access, streaming, collision and address checking.
// -----------------------------------------------------------------------------
module tb_dram_resp;
    import dram_pkg::*;

    localparam int NDUT = 3;

    logic  clk;
    logic  srstn;
    logic  dram_en_rd;
    addr_t addr_rd;
    logic  dram_en_wr;
    addr_t addr_wr;
    word_t data_wr;

    word_t       data_rd_o  [NDUT];
    logic        valid_o    [NDUT];
    logic [31:0] rd_cnt_o   [NDUT];
    logic [31:0] wr_cnt_o   [NDUT];
`ifdef DRAM_RESP_ADDR_CHK_EN
    logic        addr_err_o [NDUT];
    word_t       data_chk;
    logic        valid_chk;
    logic        err_chk;
    logic [31:0] rd_cnt_chk, wr_cnt_chk;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference state
    word_t mem_m [int];
    logic  pv [NDUT][MAX_RD_LAT];
    word_t pd [NDUT][MAX_RD_LAT];
    word_t last_d [NDUT];
    int    rdc, wrc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
        dram_resp #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (18),
            .MEM_DEPTH  (262144),
            .RD_LAT     (LAT),
            .CNT_WIDTH  (32)
        ) u_dut (
            .clk        (clk),
            .srstn      (srstn),
            .dram_en_rd (dram_en_rd),
            .addr_rd    (addr_rd),
            .dram_en_wr (dram_en_wr),
            .addr_wr    (addr_wr),
            .data_wr    (data_wr),
            .data_rd    (data_rd_o[gi]),
            .dram_valid (valid_o[gi]),
`ifdef DRAM_RESP_ADDR_CHK_EN
            .addr_err   (addr_err_o[gi]),
`endif
            .rd_cnt     (rd_cnt_o[gi]),
            .wr_cnt     (wr_cnt_o[gi])
        );
    end

`ifdef DRAM_RESP_ADDR_CHK_EN
    dram_resp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (18),
        .MEM_DEPTH  (1024),
        .RD_LAT     (2),
        .CNT_WIDTH  (32)
    ) u_chk (
        .clk        (clk),
        .srstn      (srstn),
        .dram_en_rd (dram_en_rd),
        .addr_rd    (addr_rd),
        .dram_en_wr (dram_en_wr),
        .addr_wr    (addr_wr),
        .data_wr    (data_wr),
        .data_rd    (data_chk),
        .dram_valid (valid_chk),
        .addr_err   (err_chk),
        .rd_cnt     (rd_cnt_chk),
        .wr_cnt     (wr_cnt_chk)
    );
`endif

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 8);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < NDUT; d++) begin
            for (int s = 0; s < MAX_RD_LAT; s++) begin
                pv[d][s] = 1'b0;
                pd[d][s] = '0;
            end
            last_d[d] = '0;
        end
        rdc = 0;
        wrc = 0;
    endtask

    // One clock: reference update at the rising edge, compare at the falling edge.
    task automatic tick();
        word_t rword;
        int    lat;
        logic  ev;
        @(posedge clk);
        rword = mem_m.exists(int'(addr_rd)) ? mem_m[int'(addr_rd)] : '0;
        for (int d = 0; d < NDUT; d++) begin
            for (int s = MAX_RD_LAT - 1; s > 0; s--) begin
                pv[d][s] = pv[d][s-1];
                pd[d][s] = pd[d][s-1];
            end
            pv[d][0] = dram_en_rd;
            pd[d][0] = rword;
        end
        if (dram_en_wr) mem_m[int'(addr_wr)] = data_wr;
        if (dram_en_rd) rdc++;
        if (dram_en_wr) wrc++;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            lat = lat_of(d);
            ev  = pv[d][lat-1];
            if (ev) last_d[d] = pd[d][lat-1];
            check($sformatf("valid_lat%0d", lat), 64'(valid_o[d]), 64'(ev));
            check($sformatf("data_lat%0d", lat), 64'(data_rd_o[d]), 64'(last_d[d]));
            check($sformatf("rd_cnt_lat%0d", lat), 64'(rd_cnt_o[d]), 64'(rdc));
            check($sformatf("wr_cnt_lat%0d", lat), 64'(wr_cnt_o[d]), 64'(wrc));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_valid%0d", tag, d), 64'(valid_o[d]), 64'(0));
            check($sformatf("%s_data%0d", tag, d), 64'(data_rd_o[d]), 64'(0));
            check($sformatf("%s_rdcnt%0d", tag, d), 64'(rd_cnt_o[d]), 64'(0));
            check($sformatf("%s_wrcnt%0d", tag, d), 64'(wr_cnt_o[d]), 64'(0));
        end
    endtask

    initial begin
        word_t exp0;
        srstn      = 1'b1;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_rd    = '0;
        addr_wr    = '0;
        data_wr    = '0;
        model_clear();
        #1 srstn = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
`ifdef DRAM_RESP_ADDR_CHK_EN
        check("chk_err_reset", 64'(err_chk), 64'(0));
`endif
        srstn = 1'b1;
        $display("step: reset released");

        // Single access: write 0x0001_8000 to 5, read 5 at edge N
        dram_en_wr = 1'b1; addr_wr = 18'd5; data_wr = 32'h0001_8000;
        tick();
        dram_en_wr = 1'b0;
        dram_en_rd = 1'b1; addr_rd = 18'd5;
        tick();
        dram_en_rd = 1'b0;
        check("single_not_early", 64'(valid_o[0]), 64'(0));
        tick();
        check("single_valid", 64'(valid_o[0]), 64'(1));
        check("single_data", 64'(data_rd_o[0]), 64'(32'h0001_8000));
        check("single_rdcnt", 64'(rd_cnt_o[0]), 64'(1));
        check("single_wrcnt", 64'(wr_cnt_o[0]), 64'(1));
        tick();
        check("single_one_strobe", 64'(valid_o[0]), 64'(0));
        check("single_hold", 64'(data_rd_o[0]), 64'(32'h0001_8000));
        $display("step: single access done");

        // Reset with reads in flight
        dram_en_rd = 1'b1; addr_rd = 18'd5;
        tick();
        tick();
        dram_en_rd = 1'b0;
        #2 srstn = 1'b0;
        model_clear();
        #1 check_zero("inflight_reset");
        @(negedge clk);
        @(negedge clk);
        srstn = 1'b1;
        repeat (12) tick();
        $display("step: reset with reads in flight done");

        // Streaming: fill 0..31 with addr*3, read 0..24 back to back
        for (int a = 0; a < 32; a++) begin
            dram_en_wr = 1'b1; addr_wr = 18'(a); data_wr = 32'(a * 3);
            tick();
        end
        dram_en_wr = 1'b0;
        for (int a = 0; a < 25; a++) begin
            dram_en_rd = 1'b1; addr_rd = 18'(a);
            tick();
            if (a >= 1) begin
                check($sformatf("stream_word%0d", a - 1), 64'(data_rd_o[0]), 64'((a - 1) * 3));
            end
        end
        dram_en_rd = 1'b0;
        tick();
        check("stream_last", 64'(data_rd_o[0]), 64'(72));
        check("stream_rdcnt", 64'(rd_cnt_o[0]), 64'(25));
        repeat (8) tick();
        $display("step: streaming done");

        // Collision: read 7 and write 7 on one edge
        dram_en_wr = 1'b1; addr_wr = 18'd7; data_wr = 32'hAAAA_AAAA;
        tick();
        dram_en_rd = 1'b1; addr_rd = 18'd7; data_wr = 32'h5555_5555;
        tick();
        dram_en_wr = 1'b0;
        tick();
        dram_en_rd = 1'b0;
        check("collide_old", 64'(data_rd_o[0]), 64'(32'hAAAA_AAAA));
        tick();
        check("collide_new", 64'(data_rd_o[0]), 64'(32'h5555_5555));
        repeat (8) tick();
        $display("step: collision done");

        // Latency sweep: read and write every cycle for 100 cycles
        for (int c = 0; c < 100; c++) begin
            dram_en_rd = 1'b1; addr_rd = 18'($urandom_range(31, 0));
            dram_en_wr = 1'b1; addr_wr = 18'($urandom_range(31, 0));
            data_wr    = $urandom;
            tick();
        end
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        repeat (12) tick();
        $display("step: latency sweep done");

`ifdef DRAM_RESP_ADDR_CHK_EN
        check("chk_err_clean", 64'(err_chk), 64'(0));
        dram_en_wr = 1'b1; addr_wr = 18'd1024; data_wr = 32'h0000_1234;
        tick();
        dram_en_wr = 1'b0;
        check("chk_err_set", 64'(err_chk), 64'(1));
        dram_en_rd = 1'b1; addr_rd = 18'd1024;
        tick();
        dram_en_rd = 1'b0;
        tick();
        check("chk_oob_valid", 64'(valid_chk), 64'(1));
        check("chk_oob_data", 64'(data_chk), 64'(0));
        exp0 = mem_m[0];
        dram_en_rd = 1'b1; addr_rd = 18'd0;
        tick();
        dram_en_rd = 1'b0;
        tick();
        check("chk_mem0_valid", 64'(valid_chk), 64'(1));
        check("chk_mem0_data", 64'(data_chk), 64'(exp0));
        check("chk_err_sticky", 64'(err_chk), 64'(1));
        $display("step: address check done");
`else
        exp0 = '0;
        check("final_idle", 64'(valid_o[0]), 64'(exp0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dram_resp
